cordic_sincos: RTL

Iterative rotation-mode CORDIC that takes an angle in radians and returns its cosine and sine. It is the forward counterpart to the pipelined arctangent (vectoring-mode) CORDIC and uses the same Q2.30 angle format and arctangent constants, so a result from one can be fed directly into the other. It performs one micro-rotation per clock through a start/busy/done handshake. Its outputs feed the tan/ratio path and the BCD/7-segment display chain.

---
 rtl/cordic_sincos_if.sv | 20 ++
 rtl/cordic_sincos.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/cordic_sincos_if.sv
// rtl/cordic_sincos_if.sv - start/busy/done handshake and result bundle for the sin/cos CORDIC
interface cordic_sincos_if;
  logic               start;
  logic signed [31:0] angle;
  logic               busy;
  logic               done;
  logic signed [31:0] cos_out;
  logic signed [31:0] sin_out;
  logic               range_err;

  modport master (
    output start, angle,
    input  busy, done, cos_out, sin_out, range_err
  );

  modport slave (
    input  start, angle,
    output busy, done, cos_out, sin_out, range_err
  );
endinterface

// File: rtl/cordic_sincos.sv
// rtl/cordic_sincos.sv - iterative rotation-mode CORDIC, Q2.30 angle in, Q2.30 cos/sin out
module cordic_sincos #(
  parameter int ITER = 16
) (
  input  logic           clk,
  input  logic           reset,
  cordic_sincos_if.slave bus
);

  localparam logic signed [31:0] K_INIT    = 32'sd652032874;
  localparam logic signed [31:0] HALF_PI   = 32'sd1686629713;
  localparam logic        [3:0]  LAST_ITER = 4'(ITER - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic signed [31:0] x_q, x_d;
  logic signed [31:0] y_q, y_d;
  logic signed [31:0] z_q, z_d;
  logic        [3:0]  i_q, i_d;
  logic               oor_q, oor_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic signed [31:0] cos_q, cos_d;
  logic signed [31:0] sin_q, sin_d;

  logic signed [31:0] x_shr, y_shr, atan_i;
  logic signed [31:0] x_nx, y_nx, z_nx;

  function automatic logic signed [31:0] atan_lookup(input logic [3:0] idx);
    case (idx)
      4'd0:    atan_lookup = 32'sd843314857;
      4'd1:    atan_lookup = 32'sd497837830;
      4'd2:    atan_lookup = 32'sd263043837;
      4'd3:    atan_lookup = 32'sd133525159;
      4'd4:    atan_lookup = 32'sd67021687;
      4'd5:    atan_lookup = 32'sd33543516;
      4'd6:    atan_lookup = 32'sd16775851;
      4'd7:    atan_lookup = 32'sd8388438;
      4'd8:    atan_lookup = 32'sd4194283;
      4'd9:    atan_lookup = 32'sd2097150;
      4'd10:   atan_lookup = 32'sd1048576;
      4'd11:   atan_lookup = 32'sd524288;
      4'd12:   atan_lookup = 32'sd262144;
      4'd13:   atan_lookup = 32'sd131072;
      4'd14:   atan_lookup = 32'sd65536;
      default: atan_lookup = 32'sd32768;
    endcase
  endfunction

  // One micro-rotation; direction follows the sign of the residual angle.
  always_comb begin
    x_shr  = x_q >>> i_q;
    y_shr  = y_q >>> i_q;
    atan_i = atan_lookup(i_q);
    if (!z_q[31]) begin
      x_nx = x_q - y_shr;
      y_nx = y_q + x_shr;
      z_nx = z_q - atan_i;
    end else begin
      x_nx = x_q + y_shr;
      y_nx = y_q - x_shr;
      z_nx = z_q + atan_i;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    i_d     = i_q;
    oor_d   = oor_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = err_q;
    cos_d   = cos_q;
    sin_d   = sin_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = RUN;
          x_d     = K_INIT;
          y_d     = '0;
          z_d     = bus.angle;
          i_d     = '0;
          oor_d   = (bus.angle > HALF_PI) || (bus.angle < -HALF_PI);
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        x_d = x_nx;
        y_d = y_nx;
        z_d = z_nx;
        i_d = i_q + 4'd1;
        if (i_q == LAST_ITER) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          err_d   = oor_q;
          // Out-of-range requests still burn the full latency but report zeros.
          cos_d   = oor_q ? 32'sd0 : x_nx;
          sin_d   = oor_q ? 32'sd0 : y_nx;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      i_q     <= '0;
      oor_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      cos_q   <= '0;
      sin_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      i_q     <= i_d;
      oor_q   <= oor_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      cos_q   <= cos_d;
      sin_q   <= sin_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.range_err = err_q;
  assign bus.cos_out   = cos_q;
  assign bus.sin_out   = sin_q;

endmodule
